// File: rtl/apb_periph_guard.sv
// -----------------------------------------------------------------------------
// apb_periph_guard
//
// Registered APB3 slice placed between the SoC UART APB master port and the
// UART peripheral. Each upstream transfer is captured in IDLE and replayed
// downstream one cycle later, so the APB path is registered on both sides.
//
// Besides forwarding, the slice protects the CPU against two failure modes:
//   * misaligned addresses (paddr[1:0] != 0) are answered locally with an
//     error response, and the peripheral is never selected;
//   * a peripheral that never raises PREADY (dead or unclocked) is aborted
//     by a watchdog after TimeoutCycles ACCESS cycles, and an error response
//     is returned.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   s_*                   upstream APB3 slave side (from the SoC master)
//   m_*                   downstream APB3 master side (to the peripheral)
//   timeout_cnt_o         saturating count of watchdog aborts
//   err_pulse_o           one-cycle pulse with every locally generated error
//
// Every output comes straight from a flop. Output flops are loaded from the
// values that belong to the *next* state, so they change together with the
// state register and no output lags the FSM.
// -----------------------------------------------------------------------------
module apb_periph_guard #(
   parameter int                   AddrWidth     = 32,
   parameter int                   DataWidth     = 32,
   parameter int                   TimeoutCycles = 1024,
   parameter logic [DataWidth-1:0] ErrData       = 'hDEADBEEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // upstream (slave) side
   input  logic                 s_psel_i,
   input  logic                 s_penable_i,
   input  logic                 s_pwrite_i,
   input  logic [AddrWidth-1:0] s_paddr_i,
   input  logic [DataWidth-1:0] s_pwdata_i,
   output logic [DataWidth-1:0] s_prdata_o,
   output logic                 s_pready_o,
   output logic                 s_pslverr_o,
   // downstream (master) side
   output logic                 m_psel_o,
   output logic                 m_penable_o,
   output logic                 m_pwrite_o,
   output logic [AddrWidth-1:0] m_paddr_o,
   output logic [DataWidth-1:0] m_pwdata_o,
   input  logic [DataWidth-1:0] m_prdata_i,
   input  logic                 m_pready_i,
   input  logic                 m_pslverr_i,
   // status
   output logic [15:0]          timeout_cnt_o,
   output logic                 err_pulse_o
);

   // ---------------------------------------------------------------------
   // FSM encoding
   // ---------------------------------------------------------------------
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_M_SETUP  = 2'd1;
   localparam logic [1:0] S_M_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   // Watchdog must be able to hold the value TimeoutCycles itself.
   localparam int WdWidth = $clog2(TimeoutCycles + 1);
   localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);
   localparam logic [WdWidth-1:0] WdOne   = WdWidth'(1);

   // ---------------------------------------------------------------------
   // State and output flops
   // ---------------------------------------------------------------------
   logic [1:0]           state_q,       state_d;
   logic [WdWidth-1:0]   wd_q,          wd_d;
   logic                 mis_q,         mis_d;

   logic                 m_psel_q,      m_psel_d;
   logic                 m_penable_q,   m_penable_d;
   logic                 m_pwrite_q,    m_pwrite_d;
   logic [AddrWidth-1:0] m_paddr_q,     m_paddr_d;
   logic [DataWidth-1:0] m_pwdata_q,    m_pwdata_d;

   logic [DataWidth-1:0] s_prdata_q,    s_prdata_d;
   logic                 s_pready_q,    s_pready_d;
   logic                 s_pslverr_q,   s_pslverr_d;
   logic                 err_pulse_q,   err_pulse_d;
   logic [15:0]          timeout_cnt_q, timeout_cnt_d;

   // Upstream SETUP phase: selected but not yet enabled.
   logic                 s_setup;
   logic                 s_misaligned;

   assign s_setup      = s_psel_i & ~s_penable_i;
   assign s_misaligned = (s_paddr_i[1:0] != 2'b00);

   // ---------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // Hold state, latched transfer and counters by default.
      state_d       = state_q;
      wd_d          = wd_q;
      mis_d         = mis_q;
      m_pwrite_d    = m_pwrite_q;
      m_paddr_d     = m_paddr_q;
      m_pwdata_d    = m_pwdata_q;
      timeout_cnt_d = timeout_cnt_q;

      // Handshake and response outputs are only ever asserted explicitly.
      m_psel_d      = 1'b0;
      m_penable_d   = 1'b0;
      s_prdata_d    = '0;
      s_pready_d    = 1'b0;
      s_pslverr_d   = 1'b0;
      err_pulse_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Upstream inputs are only looked at here; anything the master
            // does while a transfer is in flight is ignored.
            if (s_setup) begin
               m_paddr_d  = s_paddr_i;
               m_pwdata_d = s_pwdata_i;
               m_pwrite_d = s_pwrite_i;
               mis_d      = s_misaligned;
               state_d    = S_M_SETUP;
               // A misaligned transfer spends its M_SETUP slot with the
               // downstream select masked, so the peripheral never sees it.
               m_psel_d   = ~s_misaligned;
            end
         end

         S_M_SETUP: begin
            if (mis_q) begin
               // Locally generated alignment error.
               state_d     = S_RESP;
               s_pready_d  = 1'b1;
               s_prdata_d  = m_pwrite_q ? '0 : ErrData;
               s_pslverr_d = 1'b1;
               err_pulse_d = 1'b1;
            end else begin
               state_d     = S_M_ACCESS;
               m_psel_d    = 1'b1;
               m_penable_d = 1'b1;
               // First ACCESS cycle is watchdog count 1.
               wd_d        = WdOne;
            end
         end

         S_M_ACCESS: begin
            if (m_pready_i) begin
               // Completion has priority over a watchdog hit in the same
               // cycle. A downstream PSLVERR is passed through untouched and
               // is not a local error, so no pulse.
               state_d     = S_RESP;
               s_pready_d  = 1'b1;
               s_prdata_d  = m_pwrite_q ? '0 : m_prdata_i;
               s_pslverr_d = m_pslverr_i;
            end else if (wd_q == WdLimit) begin
               // Abort: release the downstream bus and answer upstream.
               state_d     = S_RESP;
               s_pready_d  = 1'b1;
               s_prdata_d  = m_pwrite_q ? '0 : ErrData;
               s_pslverr_d = 1'b1;
               err_pulse_d = 1'b1;
               if (timeout_cnt_q != 16'hFFFF) begin
                  timeout_cnt_d = timeout_cnt_q + 16'd1;
               end
            end else begin
               m_psel_d    = 1'b1;
               m_penable_d = 1'b1;
               wd_d        = wd_q + WdOne;
            end
         end

         S_RESP: begin
            // The single response cycle is presented by the output flops;
            // a late downstream PREADY here or in IDLE has no effect.
            state_d = S_IDLE;
            wd_d    = '0;
            mis_d   = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         wd_q          <= '0;
         mis_q         <= 1'b0;
         m_psel_q      <= 1'b0;
         m_penable_q   <= 1'b0;
         m_pwrite_q    <= 1'b0;
         m_paddr_q     <= '0;
         m_pwdata_q    <= '0;
         s_prdata_q    <= '0;
         s_pready_q    <= 1'b0;
         s_pslverr_q   <= 1'b0;
         err_pulse_q   <= 1'b0;
         timeout_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         wd_q          <= wd_d;
         mis_q         <= mis_d;
         m_psel_q      <= m_psel_d;
         m_penable_q   <= m_penable_d;
         m_pwrite_q    <= m_pwrite_d;
         m_paddr_q     <= m_paddr_d;
         m_pwdata_q    <= m_pwdata_d;
         s_prdata_q    <= s_prdata_d;
         s_pready_q    <= s_pready_d;
         s_pslverr_q   <= s_pslverr_d;
         err_pulse_q   <= err_pulse_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign s_prdata_o    = s_prdata_q;
   assign s_pready_o    = s_pready_q;
   assign s_pslverr_o   = s_pslverr_q;
   assign m_psel_o      = m_psel_q;
   assign m_penable_o   = m_penable_q;
   assign m_pwrite_o    = m_pwrite_q;
   assign m_paddr_o     = m_paddr_q;
   assign m_pwdata_o    = m_pwdata_q;
   assign timeout_cnt_o = timeout_cnt_q;
   assign err_pulse_o   = err_pulse_q;

endmodule

// File: tb/tb_apb_periph_guard.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for apb_periph_guard.
// The stimulus process issues upstream transfers and pushes the expected
// upstream response (data, error, pulse, arrival cycle) and the expected
// downstream SETUP (addr, write, data, ACCESS length) into queues. Two
// monitors pop and compare whenever the DUT presents s_pready_o or a
// downstream SETUP phase. A small downstream slave model answers with a
// programmable number of wait states.
// -----------------------------------------------------------------------------
module tb_apb_periph_guard;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          s_psel_i = 1'b0;
   logic          s_penable_i = 1'b0;
   logic          s_pwrite_i = 1'b0;
   logic [AW-1:0] s_paddr_i = '0;
   logic [DW-1:0] s_pwdata_i = '0;
   logic [DW-1:0] s_prdata_o;
   logic          s_pready_o;
   logic          s_pslverr_o;
   logic          m_psel_o;
   logic          m_penable_o;
   logic          m_pwrite_o;
   logic [AW-1:0] m_paddr_o;
   logic [DW-1:0] m_pwdata_o;
   logic [DW-1:0] m_prdata_i = '0;
   logic          m_pready_i = 1'b0;
   logic          m_pslverr_i = 1'b0;
   logic [15:0]   timeout_cnt_o;
   logic          err_pulse_o;

   apb_periph_guard #(
      .AddrWidth    (AW),
      .DataWidth    (DW),
      .TimeoutCycles(TO),
      .ErrData      (32'hDEADBEEF)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .s_psel_i     (s_psel_i),
      .s_penable_i  (s_penable_i),
      .s_pwrite_i   (s_pwrite_i),
      .s_paddr_i    (s_paddr_i),
      .s_pwdata_i   (s_pwdata_i),
      .s_prdata_o   (s_prdata_o),
      .s_pready_o   (s_pready_o),
      .s_pslverr_o  (s_pslverr_o),
      .m_psel_o     (m_psel_o),
      .m_penable_o  (m_penable_o),
      .m_pwrite_o   (m_pwrite_o),
      .m_paddr_o    (m_paddr_o),
      .m_pwdata_o   (m_pwdata_o),
      .m_prdata_i   (m_prdata_i),
      .m_pready_i   (m_pready_i),
      .m_pslverr_i  (m_pslverr_i),
      .timeout_cnt_o(timeout_cnt_o),
      .err_pulse_o  (err_pulse_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        pulse;
      int          at_cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          acc;
   } setup_t;

   resp_t  resp_q[$];
   setup_t setup_q[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- downstream slave model ----------------
   int          slv_wait = 0;      // wait cycles before PREADY, -1 = never
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0;
   logic        force_pready = 1'b0;
   int          acc_cnt = 0;

   always @(posedge clk_i) begin
      #2;
      if (m_psel_o && m_penable_o) acc_cnt = acc_cnt + 1;
      else                         acc_cnt = 0;
      m_pready_i  = force_pready ||
                    (m_psel_o && m_penable_o && slv_wait >= 0 && acc_cnt > slv_wait);
      m_prdata_i  = m_pready_i ? slv_rdata : '0;
      m_pslverr_i = m_pready_i & slv_err;
   end

   // ---------------- upstream monitor ----------------
   resp_t um_r;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (s_pready_o) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               um_r = resp_q.pop_front();
               chk("s_prdata",    s_prdata_o,  um_r.rdata);
               chk("s_pslverr",   s_pslverr_o, um_r.err);
               chk("err_pulse",   err_pulse_o, um_r.pulse);
               chk("resp_cycle",  cyc,         um_r.at_cyc);
               $display("resp cyc=%0d prdata=0x%08h pslverr=%0b err_pulse=%0b",
                        cyc, s_prdata_o, s_pslverr_o, err_pulse_o);
            end
         end else begin
            chk("idle_resp_zero", {s_prdata_o, s_pslverr_o, err_pulse_o}, '0);
         end
      end
   end

   // ---------------- downstream monitor ----------------
   setup_t dm_s;
   logic   dm_have = 1'b0;
   int     dm_run = 0;
   always @(negedge clk_i) begin
      if (m_psel_o && !m_penable_o) begin
         if (setup_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_m_setup: got addr 0x%0h expected none (cycle %0d)",
                     m_paddr_o, cyc);
         end else begin
            dm_s = setup_q.pop_front();
            chk("m_paddr",  m_paddr_o,  dm_s.addr);
            chk("m_pwrite", m_pwrite_o, dm_s.wr);
            if (dm_s.wr) chk("m_pwdata", m_pwdata_o, dm_s.wdata);
            dm_have = 1'b1;
            dm_run  = 0;
         end
      end else if (m_psel_o && m_penable_o) begin
         dm_run = dm_run + 1;
      end else if (dm_have) begin
         chk("access_cycles", dm_run, dm_s.acc);
         dm_have = 1'b0;
      end
   end

   // ---------------- upstream master ----------------
   // lat: cycles from upstream SETUP to s_pready; acc: expected downstream
   // ACCESS cycles (0 = downstream must not be selected).
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_pulse, input int lat, input int acc);
      resp_t  r;
      setup_t s;
      int     n;
      @(posedge clk_i); #1;
      s_psel_i    = 1'b1;
      s_penable_i = 1'b0;
      s_pwrite_i  = wr;
      s_paddr_i   = addr;
      s_pwdata_i  = wdata;
      r = '{exp_rdata, exp_err, exp_pulse, cyc + lat};
      resp_q.push_back(r);
      if (acc > 0) begin
         s = '{addr, wr, wdata, acc};
         setup_q.push_back(s);
      end
      $display("xfer cyc=%0d %s addr=0x%08h wdata=0x%08h", cyc, wr ? "WR" : "RD", addr, wdata);
      @(posedge clk_i); #1;
      s_penable_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!s_pready_o && n < 50);
      if (!s_pready_o) begin
         checks++;
         errors++;
         $display("FAIL pready_timeout: got no s_pready expected within 50 cycles");
      end
      @(posedge clk_i); #1;
      s_psel_i    = 1'b0;
      s_penable_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_s_pready",  s_pready_o,    1'b0);
      chk("rst_m_psel",    m_psel_o,      1'b0);
      chk("rst_timeout",   timeout_cnt_o, 16'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // 1: zero-wait write; write data returns 0 regardless of PRDATA
      slv_wait = 0; slv_rdata = 32'h99; slv_err = 1'b0;
      apb_xfer(32'h0, 1'b1, 32'h41, 32'h0, 1'b0, 1'b0, 3, 1);

      // 2: read with 5 wait states
      slv_wait = 5; slv_rdata = 32'h60;
      apb_xfer(32'h14, 1'b0, 32'h0, 32'h60, 1'b0, 1'b0, 8, 6);

      // 3: misaligned read, then misaligned write (no data on writes)
      apb_xfer(32'h6, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 2, 0);
      apb_xfer(32'h3, 1'b1, 32'h12, 32'h0, 1'b1, 1'b1, 2, 0);

      // downstream PSLVERR passes through without a pulse
      slv_wait = 0; slv_rdata = 32'h55; slv_err = 1'b1;
      apb_xfer(32'h10, 1'b0, 32'h0, 32'h55, 1'b1, 1'b0, 3, 1);
      slv_err = 1'b0;

      // 4: watchdog abort after 8 ACCESS cycles
      chk("timeout_cnt_before", timeout_cnt_o, 16'd0);
      slv_wait = -1;
      apb_xfer(32'h8, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 10, 8);
      @(negedge clk_i);
      chk("timeout_cnt_after", timeout_cnt_o, 16'd1);
      // late PREADY must be ignored
      @(posedge clk_i); #1;
      force_pready = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 force_pready = 1'b0;
      @(negedge clk_i);
      chk("late_pready_m_psel", m_psel_o, 1'b0);
      chk("late_pready_cnt",    timeout_cnt_o, 16'd1);

      // 5: PREADY exactly on watchdog cycle 8 completes normally
      slv_wait = 7; slv_rdata = 32'h77;
      apb_xfer(32'hC, 1'b0, 32'h0, 32'h77, 1'b0, 1'b0, 10, 8);
      @(negedge clk_i);
      chk("edge_timeout_cnt", timeout_cnt_o, 16'd1);

      // 6: reset while in M_ACCESS
      slv_wait = -1;
      begin
         setup_t s;
         @(posedge clk_i); #1;
         s_psel_i = 1'b1; s_penable_i = 1'b0; s_pwrite_i = 1'b0; s_paddr_i = 32'h20;
         s = '{32'h20, 1'b0, 32'h0, 2};
         setup_q.push_back(s);
         $display("xfer cyc=%0d RD addr=0x%08h (reset in ACCESS)", cyc, 32'h20);
         @(posedge clk_i); #1;
         s_penable_i = 1'b1;
         @(posedge clk_i); #1;
         @(posedge clk_i); #1;
         rst_i = 1'b1;
         s_psel_i = 1'b0; s_penable_i = 1'b0;
         @(posedge clk_i);
         @(negedge clk_i);
         chk("rst6_m_psel",    m_psel_o,      1'b0);
         chk("rst6_m_penable", m_penable_o,   1'b0);
         chk("rst6_s_pready",  s_pready_o,    1'b0);
         chk("rst6_m_paddr",   m_paddr_o,     32'h0);
         chk("rst6_timeout",   timeout_cnt_o, 16'h0);
         chk("rst6_err_pulse", err_pulse_o,   1'b0);
         @(posedge clk_i); #1;
         rst_i = 1'b0;
      end
      slv_wait = 0; slv_rdata = 32'h0;
      apb_xfer(32'h4, 1'b1, 32'h42, 32'h0, 1'b0, 1'b0, 3, 1);

      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      chk("resp_queue_empty",  resp_q.size(),  0);
      chk("setup_queue_empty", setup_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
